// File: rtl/rr_priority_encoder.sv
// Registered priority encoder with fixed-priority or round-robin selection.
// Latency: 1 cycle from accept to out_valid; 1 result/cycle sustained.
// Backpressure: single output register, in_ready = !out_valid || out_ready.
module rr_priority_encoder #(
    parameter int M = 8,
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M-1:0] in,
    input  logic         mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out,
    output logic         out_zero,
    output logic [N-1:0] rr_ptr
);

    // Elaboration-time sanity checks on the parameter pair
    if (M < 2) begin : g_bad_m
        $error("rr_priority_encoder: M must be at least 2");
    end
    if ((1 << N) < M) begin : g_bad_n
        $error("rr_priority_encoder: N too narrow to encode M requesters");
    end

    logic         r_out_valid;
    logic [N-1:0] r_out;
    logic         r_out_zero;
    logic [N-1:0] r_rr_ptr;

    logic         w_accept;
    logic         w_any;
    logic [N-1:0] w_fixed_idx;
    logic [N-1:0] w_rr_idx;
    logic [N-1:0] w_rr_next;
    logic [N-1:0] w_win_idx;

    assign in_ready  = !r_out_valid || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign w_any     = |in;

    assign out_valid = r_out_valid;
    assign out       = r_out;
    assign out_zero  = r_out_zero;
    assign rr_ptr    = r_rr_ptr;

    // Fixed priority: scanning upward lets the highest set bit overwrite lower ones
    always_comb begin
        w_fixed_idx = '0;
        for (int i = 0; i < M; i++) begin
            if (in[i]) begin
                w_fixed_idx = N'(i);
            end
        end
    end

    // Round-robin: first set bit walking from rr_ptr upward with wrap at M
    always_comb begin
        logic found;
        int   idx;
        w_rr_idx = '0;
        found    = 1'b0;
        idx      = 0;
        for (int k = 0; k < M; k++) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= M) begin
                idx = idx - M;
            end
            if (!found && in[idx]) begin
                found    = 1'b1;
                w_rr_idx = N'(idx);
            end
        end
    end

    // Winner selection and the pointer value that follows a round-robin grant
    always_comb begin
        w_win_idx = mode ? w_rr_idx : w_fixed_idx;
        w_rr_next = (w_rr_idx == N'(M - 1)) ? '0 : w_rr_idx + N'(1);
    end

    // Output register and pointer state; reset overrides any accept
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_out_zero  <= 1'b0;
            r_rr_ptr    <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out       <= w_any ? w_win_idx : '0;
            r_out_zero  <= !w_any;
            if (mode && w_any) begin
                r_rr_ptr <= w_rr_next;
            end
        end else if (out_ready) begin
            // Drain: result consumed, keep the last encoded value on the bus
            r_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_priority_encoder.sv
module tb_rr_priority_encoder;

    localparam int M = 8;
    localparam int N = 3;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [M-1:0] in_vec;
    logic         mode;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_idx;
    logic         out_zero;
    logic [N-1:0] rr_ptr;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    int m_valid = 0;
    int m_out   = 0;
    int m_zero  = 0;
    int m_ptr   = 0;

    rr_priority_encoder #(.M(M), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in_vec),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out_idx),
        .out_zero  (out_zero),
        .rr_ptr    (rr_ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       iv;
        logic       md;
        logic [7:0] vin;
        logic       ordy;
        int         ev;
        int         eo;
        int         ez;
        int         ep;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int fixed_win(input logic [M-1:0] v);
        for (int i = M - 1; i >= 0; i--) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    function automatic int rr_win(input logic [M-1:0] v, input int p);
        for (int k = 0; k < M; k++) begin
            if (v[(p + k) % M]) return (p + k) % M;
        end
        return 0;
    endfunction

    // Advance one clock, updating the model from the inputs seen at the edge
    task automatic tick();
        int nv, no, nz, np;
        nv = m_valid; no = m_out; nz = m_zero; np = m_ptr;
        if (rst) begin
            nv = 0; no = 0; nz = 0; np = 0;
        end else if (in_valid && (m_valid == 0 || out_ready)) begin
            nv = 1;
            if (in_vec == '0) begin
                no = 0; nz = 1;
            end else begin
                nz = 0;
                no = mode ? rr_win(in_vec, m_ptr) : fixed_win(in_vec);
                if (mode) np = (no + 1) % M;
            end
        end else if (out_ready) begin
            nv = 0;
        end
        @(posedge clk);
        #1;
        m_valid = nv; m_out = no; m_zero = nz; m_ptr = np;
    endtask

    task automatic drive(input logic r, input logic iv, input logic md,
                         input logic [7:0] v, input logic ordy);
        rst = r; in_valid = iv; mode = md; in_vec = v; out_ready = ordy;
    endtask

    task automatic expect_state(input string tag, input int ev, input int eo,
                                input int ez, input int ep, input int erdy);
        chk($sformatf("%s.out_valid", tag), int'(out_valid), ev);
        chk($sformatf("%s.out", tag), int'(out_idx), eo);
        chk($sformatf("%s.out_zero", tag), int'(out_zero), ez);
        chk($sformatf("%s.rr_ptr", tag), int'(rr_ptr), ep);
        chk($sformatf("%s.in_ready", tag), int'(in_ready), erdy);
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

        // Reset, fixed mode, round-robin wrap, mode interleave, drain
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 0, 0, 0, 0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 0, 0, 0, 0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 0, 0, 0, 0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 8'h01, 1'b1, 1, 0, 0, 0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 8'h94, 1'b1, 1, 7, 0, 0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1, 0, 1, 0};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 8'h85, 1'b1, 1, 0, 0, 1};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 8'h85, 1'b1, 1, 2, 0, 3};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 8'h85, 1'b1, 1, 7, 0, 0};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 8'h85, 1'b1, 1, 0, 0, 1};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 8'h08, 1'b1, 1, 3, 0, 4};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 8'h03, 1'b1, 1, 1, 0, 4};
        tbl[12] = '{1'b0, 1'b1, 1'b1, 8'h03, 1'b1, 1, 0, 0, 1};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 0, 0, 0, 1};

        @(negedge clk);
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].rst, tbl[i].iv, tbl[i].md, tbl[i].vin, tbl[i].ordy);
            tick();
            expect_state($sformatf("vec%0d", i), tbl[i].ev, tbl[i].eo,
                         tbl[i].ez, tbl[i].ep, 1);
        end

        // Backpressure: result 4 held for 3 cycles while a new vector waits
        drive(1'b0, 1'b1, 1'b0, 8'h10, 1'b1);
        tick();
        expect_state("bp_first", 1, 4, 0, 1, 1);
        drive(1'b0, 1'b1, 1'b0, 8'h02, 1'b0);
        for (int c = 0; c < 3; c++) begin
            tick();
            expect_state($sformatf("bp_hold%0d", c), 1, 4, 0, 1, 0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_rdy_comb", int'(in_ready), 1);
        tick();
        expect_state("bp_next", 1, 1, 0, 1, 1);
        in_valid = 1'b0;
        tick();
        expect_state("bp_drain", 0, 1, 0, 1, 1);

        // Reset while a result is stalled and rr_ptr is 5
        drive(1'b0, 1'b1, 1'b1, 8'h10, 1'b1);
        tick();
        expect_state("rst_setup", 1, 4, 0, 5, 1);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        expect_state("rst_stall", 1, 4, 0, 5, 0);
        drive(1'b1, 1'b1, 1'b1, 8'hFF, 1'b0);
        tick();
        expect_state("rst_hit", 0, 0, 0, 0, 1);
        drive(1'b0, 1'b1, 1'b1, 8'h21, 1'b1);
        tick();
        expect_state("rst_after", 1, 0, 0, 1, 1);

        // Randomised traffic against the model
        for (int c = 0; c < 600; c++) begin
            rst       = ($urandom_range(0, 59) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            mode      = $urandom_range(0, 1);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) in_vec = '0;
            else if ($urandom_range(0, 3) == 0) in_vec = M'(1 << $urandom_range(0, M - 1));
            else in_vec = M'($urandom);
            tick();
            expect_state($sformatf("rnd%0d", c), m_valid, m_out, m_zero, m_ptr,
                         (m_valid == 0 || out_ready) ? 1 : 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
